// File: rtl/lzc_pkg.sv
// Shared constants and types for the leading-zero/priority encoder family.
// Holds the vector/index widths, the common vector and index types, and the
// state encoding of the mask builder FSM.
package lzc_pkg;

   localparam int unsigned LZC_WIDTH = 34;
   localparam int unsigned LZC_CNT_W = 6;

   typedef logic [LZC_WIDTH-1:0] lzc_vec_t;
   typedef logic [LZC_CNT_W-1:0] lzc_idx_t;

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } lzc_mask_state_e;

endpackage : lzc_pkg

// File: rtl/lzc_idx_dec.sv
// Combinational index-to-one-hot decoder.
// Ports:
//   idx_i      : bit index (CNT_W bits)
//   onehot_o   : one-hot vector with bit idx_i set; all zero when idx_i >= WIDTH
//   in_range_o : idx_i < WIDTH
module lzc_idx_dec #(
   parameter int unsigned WIDTH = 34,
   parameter int unsigned CNT_W = $clog2(WIDTH)
) (
   input  logic [CNT_W-1:0] idx_i,
   output logic [WIDTH-1:0] onehot_o,
   output logic             in_range_o
);

   // Only indices that map onto a real bit position can match, so an
   // out-of-range index naturally decodes to all zero.
   always_comb begin
      onehot_o = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         onehot_o[i] = (idx_i == CNT_W'(i));
      end
   end

   assign in_range_o = (32'(idx_i) < WIDTH);

endmodule : lzc_idx_dec

// File: rtl/lzc_mask_builder.sv
// Rebuilds a WIDTH-bit request vector from a stream of bit indices.
// Each accepted index sets its bit; a last-tagged beat closes the vector,
// which is then held on a valid/ready output until the consumer takes it.
// Optional feature macro: LZC_MASK_RANGE_CHK_EN (sticky out-of-range flag).
// Ports:
//   clk_i, rst_i      : clock, asynchronous active-high reset
//   flush_i           : synchronous abort, clears the vector, back to ACCUM
//   idx_valid_i/ready : index beat handshake; idx_i index, idx_last_i closes
//   mask_valid_o/ready: vector handshake
//   mask_o            : rebuilt vector (driven from the register in all states)
//   mask_empty_o      : mask_o is all zero
//   mask_err_o        : out-of-range index seen in the held vector
module lzc_mask_builder
   import lzc_pkg::*;
#(
   parameter int unsigned WIDTH = LZC_WIDTH,
   parameter int unsigned CNT_W = $clog2(WIDTH)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             idx_valid_i,
   output logic             idx_ready_o,
   input  logic [CNT_W-1:0] idx_i,
   input  logic             idx_last_i,
   output logic             mask_valid_o,
   input  logic             mask_ready_i,
   output logic [WIDTH-1:0] mask_o,
   output logic             mask_empty_o,
   output logic             mask_err_o
);

   lzc_mask_state_e  state_q, state_d;
   logic [WIDTH-1:0] mask_q, mask_d;
   logic [WIDTH-1:0] onehot;
   logic [WIDTH-1:0] set_vec;
   logic             in_range;
   logic             idx_fire;
   logic             mask_fire;

   lzc_idx_dec #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_idx_dec (
      .idx_i      (idx_i),
      .onehot_o   (onehot),
      .in_range_o (in_range)
   );

   // Qualify with in_range so an out-of-range index can never set a bit,
   // regardless of how the decoder is parameterised.
   assign set_vec = in_range ? onehot : '0;

   // Handshake strobes; ready/valid are pure state decodes.
   assign idx_ready_o  = (state_q == ACCUM);
   assign mask_valid_o = (state_q == HOLD);
   assign idx_fire     = idx_valid_i & idx_ready_o;
   assign mask_fire    = mask_ready_i & mask_valid_o;

   // State and accumulation registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ACCUM;
         mask_q  <= '0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
      end
   end

   // Next-state and accumulation; flush overrides everything.
   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      if (flush_i) begin
         state_d = ACCUM;
         mask_d  = '0;
      end else begin
         case (state_q)
            ACCUM: begin
               if (idx_fire) begin
                  mask_d = mask_q | set_vec;
                  if (idx_last_i) begin
                     state_d = HOLD;
                  end
               end
            end
            HOLD: begin
               if (mask_fire) begin
                  mask_d  = '0;
                  state_d = ACCUM;
               end
            end
            default: begin
               state_d = ACCUM;
               mask_d  = '0;
            end
         endcase
      end
   end

   assign mask_o       = mask_q;
   assign mask_empty_o = ~|mask_q;

`ifdef LZC_MASK_RANGE_CHK_EN
   logic err_q, err_d;

   // Sticky per-vector error: set by any accepted out-of-range index,
   // cleared when the vector is consumed or flushed.
   always_comb begin
      err_d = err_q;
      if (flush_i || mask_fire) begin
         err_d = 1'b0;
      end else if (idx_fire && !in_range) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign mask_err_o = err_q & mask_valid_o;
`else
   assign mask_err_o = 1'b0;
`endif

endmodule : lzc_mask_builder

// File: doc/lzc_mask_builder.md
# lzc_mask_builder

Inverse companion of the leading-zero/priority encoder: rebuilds a 34-bit request vector from a stream of 6-bit bit indices. Each accepted index sets its bit in an accumulation register. A `last`-tagged beat closes the vector, which is then presented on a valid/ready output port. Used where encoded entry indices (e.g. PMP match/priority results) must be turned back into a bitmap for a downstream mask consumer.

## Interface
Parameters:
- `WIDTH`, 34: vector width.
- `CNT_W`, `$clog2(WIDTH)` = 6: index width.

Ports:
- `clk_i`, in, 1: clock.
- `rst_i`, in, 1: reset; asynchronous, active-high.
- `flush_i`, in, 1: synchronous abort; clears the vector and returns to ACCUM.
- `idx_valid_i`, in, 1: index beat valid.
- `idx_ready_o`, out, 1: index beat accepted when high together with `idx_valid_i`.
- `idx_i`, in, CNT_W: bit index to set.
- `idx_last_i`, in, 1: beat closes the current vector.
- `mask_valid_o`, out, 1: vector available.
- `mask_ready_i`, in, 1: consumer takes the vector.
- `mask_o`, out, WIDTH: rebuilt vector.
- `mask_empty_o`, out, 1: `mask_o` is all zero.
- `mask_err_o`, out, 1: an out-of-range index was seen in this vector.

## Operation
- FSM has two states: ACCUM (reset state) and HOLD.
- ACCUM:
  - `idx_ready_o`=1, `mask_valid_o`=0.
  - On handshake: `mask_q <= mask_q | onehot(idx_i)`.
  - If `idx_last_i` is also high, go to HOLD.
- HOLD:
  - `idx_ready_o`=0, `mask_valid_o`=1.
  - `mask_o`, `mask_empty_o` and `mask_err_o` are stable until the handshake.
  - On `mask_ready_i`: clear `mask_q` and the error flag, go to ACCUM.
- `mask_o` is driven directly from `mask_q` in both states. Consumers sample it only while `mask_valid_o`=1.
- Duplicate indices are idempotent: the bit stays set.
- A last beat carries its own index. An empty vector is only possible via a last beat with an out-of-range index.
- `mask_empty_o` = ~|`mask_q`. This matches the encoder's empty semantics.
- `flush_i` has highest priority in any state. The next cycle is ACCUM with mask=0 and err=0. A beat offered in the flush cycle is dropped even if `idx_ready_o` was 1.

## Timing
- Reset values: state=ACCUM, `mask_o`=0, `mask_empty_o`=1, `mask_err_o`=0, `mask_valid_o`=0, `idx_ready_o`=1.
- `idx_ready_o` and `mask_valid_o` are pure state decodes; they have no combinational path from inputs.
- Latency: last beat accepted in cycle N gives `mask_valid_o`=1 in cycle N+1.
- Output handshake in cycle M gives `idx_ready_o`=1 in M+1. There is one bubble per vector; this is intentional.
- Sustained throughput: one index per cycle within a vector.
- Reset asserted mid-vector discards the partial mask immediately (asynchronous).
- `mask_ready_i` while in ACCUM is ignored.

## Configuration
- Macro: `LZC_MASK_RANGE_CHK_EN`.
- Defined:
  - An index ≥ WIDTH (34..63) sets no bit and sets a sticky err flag.
  - `mask_err_o` reflects the flag while in HOLD and is 0 in ACCUM.
- Undefined:
  - Out-of-range indices are silently ignored and set no bit.
  - `mask_err_o` is tied to 0 and the err flop is not instantiated.

## Structure
- Shared package `lzc_pkg` holds:
  - `LZC_WIDTH`=34 and `LZC_CNT_W`=6.
  - `typedef logic [LZC_WIDTH-1:0] lzc_vec_t` and `typedef logic [LZC_CNT_W-1:0] lzc_idx_t`.
  - The FSM state enum `lzc_mask_state_e` {ACCUM, HOLD}.
  - The encoder uses the same constants.
- One sub-module, `lzc_idx_dec`: combinational index-to-one-hot decoder with an in-range flag.
  - Output is all-zero when index ≥ WIDTH.
  - Reusable elsewhere.

## Test plan
- Reset, then send beats 0, 5, 33(last), then handshake → `mask_o`=34'h2_0000_0021 valid one cycle after the last beat; `mask_empty_o`=0; `idx_ready_o` returns one cycle after `mask_ready_i`.
- Send 7, 7, 7(last) → `mask_o`=34'h80 (duplicates idempotent).
- Send 40(last) → `mask_o`=0 and `mask_empty_o`=1. `mask_err_o`=1 with `LZC_MASK_RANGE_CHK_EN`, 0 without.
- Hold `mask_ready_i`=0 for 10 cycles in HOLD while driving `idx_valid_i`=1 → `idx_ready_o`=0 throughout, `mask_o` stable, no beat absorbed.
- Send 3 and 9, then `flush_i` together with a valid beat 12(last) → next cycle ACCUM with mask=0; a subsequent 1(last) yields `mask_o`=34'h2.
- Assert `rst_i` asynchronously (mid-cycle) after beats 2 and 4 → outputs go to reset values immediately; a following 6(last) yields `mask_o`=34'h40.
